// File: rtl/reaction_timer_core.sv
// Reaction-time controller: tick divider, PRNG-scaled delay, scoring and session tracking.
// Define REACTION_AVG_EN to add the session-average accumulator and the avgScore output.
module reaction_timer_core #(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1000,
  parameter int SCORE_W     = 12,
  parameter int PRNG_W      = 8,
  parameter int DELAY_MIN   = 3000,
  parameter int DELAY_MAX   = 6000,
  parameter int TRIALS_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   iReset,
  input  logic [PRNG_W-1:0]      iPRNG,
  input  logic                   iStart,
  input  logic                   iResponse,
  input  logic                   iClearSession,
  output logic                   oStimulus,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oFalseStart,
  output logic                   oTimeout,
  output logic [SCORE_W-1:0]     currentScore,
  output logic [SCORE_W-1:0]     highScore,
  output logic [TRIALS_LOG2:0]   trialCount,
  output logic                   oSessionDone
`ifdef REACTION_AVG_EN
  ,
  output logic [SCORE_W-1:0]     avgScore
`endif
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DIV_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int RANGE   = DELAY_MAX - DELAY_MIN;
  localparam int RANGE_W = $clog2(RANGE + 1);
  localparam int PROD_W  = PRNG_W + RANGE_W;
  localparam int DELAY_W = $clog2(DELAY_MAX + 1);

  localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [SCORE_W-1:0]   SMAX       = '1;
  localparam logic [SCORE_W-1:0]   SCORE_LAST = {{(SCORE_W-1){1'b1}}, 1'b0};
  localparam logic [TRIALS_LOG2:0] N_TRIALS   = {1'b1, {TRIALS_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DIV_W-1:0]      r_div;
  logic [DELAY_W-1:0]    r_delay;
  logic [SCORE_W-1:0]    r_count;
  logic                  r_stim;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_false_start;
  logic                  r_timeout;
  logic [SCORE_W-1:0]    r_score;
  logic [SCORE_W-1:0]    r_best;
  logic [TRIALS_LOG2:0]  r_trials;
  logic                  r_session_done;

  logic                  w_tick;
  logic                  w_start_ok;
  logic                  w_delay_done;
  logic                  w_go_enter;
  logic                  w_false;
  logic                  w_hit;
  logic                  w_timeout;
  logic [PROD_W-1:0]     w_prod;
  logic [RANGE_W-1:0]    w_scaled;
  logic [DELAY_W-1:0]    w_delay_calc;
  logic [SCORE_W-1:0]    w_best_nxt;
  logic [TRIALS_LOG2:0]  w_trials_nxt;

  // Scale the random value into [DELAY_MIN, DELAY_MAX) with a multiply and shift.
  assign w_prod       = {{RANGE_W{1'b0}}, iPRNG} * PROD_W'(RANGE);
  assign w_scaled     = RANGE_W'(w_prod >> PRNG_W);
  assign w_delay_calc = DELAY_W'(DELAY_MIN) + DELAY_W'(w_scaled);

  assign w_tick       = (r_div == '0);
  assign w_start_ok   = (r_state == S_IDLE) && iStart && !r_session_done;
  assign w_delay_done = w_tick && (r_delay <= DELAY_W'(1));
  assign w_go_enter   = (r_state == S_WAIT) && !iResponse && w_delay_done;
  assign w_false      = (r_state == S_WAIT) && iResponse;
  assign w_hit        = (r_state == S_GO) && iResponse;
  assign w_timeout    = (r_state == S_GO) && !iResponse && w_tick && (r_count == SCORE_LAST);

  always_ff @(posedge clk) begin
    if (iReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iResponse) begin
          w_state_nxt = S_IDLE;
        end else if (w_delay_done) begin
          w_state_nxt = S_GO;
        end
      end
      S_GO: begin
        if (iResponse || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reloading on start and on entering GO makes the first tick land DIV cycles later.
  always_ff @(posedge clk) begin
    if (iReset || w_start_ok || w_go_enter || w_tick) begin
      r_div <= DIV_LAST;
    end else begin
      r_div <= r_div - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      r_delay <= '0;
    end else if (w_start_ok) begin
      r_delay <= w_delay_calc;
    end else if ((r_state == S_WAIT) && w_tick && (r_delay != '0)) begin
      r_delay <= r_delay - DELAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (iReset || w_go_enter) begin
      r_count <= '0;
    end else if ((r_state == S_GO) && w_tick) begin
      r_count <= r_count + SCORE_W'(1);
    end
  end

  // A session clear wins over a simultaneous valid response for best and count.
  always_comb begin
    w_best_nxt   = r_best;
    w_trials_nxt = r_trials;
    if (iClearSession) begin
      w_best_nxt   = SMAX;
      w_trials_nxt = '0;
    end else if (w_hit) begin
      if (r_count < r_best) begin
        w_best_nxt = r_count;
      end
      if (r_trials != N_TRIALS) begin
        w_trials_nxt = r_trials + (TRIALS_LOG2+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      r_stim         <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_false_start  <= 1'b0;
      r_timeout      <= 1'b0;
      r_score        <= '0;
      r_best         <= SMAX;
      r_trials       <= '0;
      r_session_done <= 1'b0;
    end else begin
      r_stim         <= (w_state_nxt == S_GO);
      r_busy         <= (w_state_nxt != S_IDLE);
      r_done         <= w_false || w_hit || w_timeout;
      if (w_start_ok) begin
        r_false_start <= 1'b0;
        r_timeout     <= 1'b0;
      end else begin
        if (w_false) begin
          r_false_start <= 1'b1;
        end
        if (w_timeout) begin
          r_timeout <= 1'b1;
        end
      end
      if (w_hit) begin
        r_score <= r_count;
      end
      r_best         <= w_best_nxt;
      r_trials       <= w_trials_nxt;
      r_session_done <= (w_trials_nxt == N_TRIALS);
    end
  end

`ifdef REACTION_AVG_EN
  logic [SCORE_W+TRIALS_LOG2-1:0] r_acc;
  logic [SCORE_W-1:0]             r_avg;

  always_ff @(posedge clk) begin
    if (iReset || iClearSession) begin
      r_acc <= '0;
      r_avg <= '0;
    end else begin
      if (w_hit) begin
        r_acc <= r_acc + {{TRIALS_LOG2{1'b0}}, r_count};
      end
      if (r_trials == N_TRIALS) begin
        r_avg <= r_acc[SCORE_W+TRIALS_LOG2-1:TRIALS_LOG2];
      end
    end
  end

  assign avgScore = r_avg;
`else
  // Build without the session average: no accumulator, no avgScore port.
`endif

  assign oStimulus    = r_stim;
  assign oBusy        = r_busy;
  assign oDone        = r_done;
  assign oFalseStart  = r_false_start;
  assign oTimeout     = r_timeout;
  assign currentScore = r_score;
  assign highScore    = r_best;
  assign trialCount   = r_trials;
  assign oSessionDone = r_session_done;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core with DIV=10, delay range [3,7), 4-bit scores, 2 trials.
module tb_reaction_timer_core;

  logic       clk;
  logic       iReset;
  logic [7:0] iPRNG;
  logic       iStart;
  logic       iResponse;
  logic       iClearSession;
  logic       oStimulus;
  logic       oBusy;
  logic       oDone;
  logic       oFalseStart;
  logic       oTimeout;
  logic [3:0] currentScore;
  logic [3:0] highScore;
  logic [1:0] trialCount;
  logic       oSessionDone;
`ifdef REACTION_AVG_EN
  logic [3:0] avgScore;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  reaction_timer_core #(
    .CLK_HZ(10), .TICK_HZ(1), .SCORE_W(4), .PRNG_W(8),
    .DELAY_MIN(3), .DELAY_MAX(7), .TRIALS_LOG2(1)
  ) dut (
    .clk(clk), .iReset(iReset), .iPRNG(iPRNG), .iStart(iStart),
    .iResponse(iResponse), .iClearSession(iClearSession),
    .oStimulus(oStimulus), .oBusy(oBusy), .oDone(oDone),
    .oFalseStart(oFalseStart), .oTimeout(oTimeout),
    .currentScore(currentScore), .highScore(highScore),
    .trialCount(trialCount), .oSessionDone(oSessionDone)
`ifdef REACTION_AVG_EN
    , .avgScore(avgScore)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] prng);
    iPRNG  = prng;
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic pulse_resp();
    iResponse = 1'b1;
    @(negedge clk);
    iResponse = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    iReset = 1'b1; iPRNG = '0; iStart = 1'b0; iResponse = 1'b0; iClearSession = 1'b0;
    wait_neg(2);
    iReset = 1'b0;
    chk("rst_high", highScore, 15);
    chk("rst_cur", currentScore, 0);
    chk("rst_trials", trialCount, 0);
    chk("rst_stim", oStimulus, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_fs", oFalseStart, 0);
    chk("rst_to", oTimeout, 0);
    chk("rst_sess", oSessionDone, 0);

    // Trial 1: PRNG 128 -> 5-tick delay, respond after 4 ticks in GO.
    pulse_start(8'd128);
    chk("t1_busy", oBusy, 1);
    wait_neg(49);
    chk("t1_stim_early", oStimulus, 0);
    wait_neg(1);
    chk("t1_stim_50", oStimulus, 1);
    wait_neg(40);
    pulse_resp();
    chk("t1_done", oDone, 1);
    chk("t1_cur", currentScore, 4);
    chk("t1_high", highScore, 4);
    chk("t1_trials", trialCount, 1);
    chk("t1_stim_off", oStimulus, 0);
    wait_neg(1);
    chk("t1_done_pulse", oDone, 0);

    // Trial 2: PRNG 255 -> 6-tick delay, score 6, completes the session.
    pulse_start(8'd255);
    wait_neg(59);
    chk("t2_stim_early", oStimulus, 0);
    wait_neg(1);
    chk("t2_stim_60", oStimulus, 1);
    wait_neg(60);
    pulse_resp();
    chk("t2_cur", currentScore, 6);
    chk("t2_high", highScore, 4);
    chk("t2_trials", trialCount, 2);
    chk("t2_sess", oSessionDone, 1);
    wait_neg(1);
`ifdef REACTION_AVG_EN
    chk("t2_avg", avgScore, 5);
`endif
    pulse_start(8'd0);
    chk("sess_start_ignored", oBusy, 0);

    iClearSession = 1'b1;
    @(negedge clk);
    iClearSession = 1'b0;
    chk("clr_high", highScore, 15);
    chk("clr_trials", trialCount, 0);
    chk("clr_sess", oSessionDone, 0);

    // Timeout: PRNG 0 -> 3-tick delay, then 15 ticks without response.
    pulse_start(8'd0);
    wait_neg(29);
    chk("t3_stim_early", oStimulus, 0);
    wait_neg(1);
    chk("t3_stim_30", oStimulus, 1);
    wait_neg(149);
    chk("t3_pre_to", oTimeout, 0);
    wait_neg(1);
    chk("t3_to", oTimeout, 1);
    chk("t3_to_stim", oStimulus, 0);
    chk("t3_to_done", oDone, 1);
    chk("t3_to_high", highScore, 15);
    chk("t3_to_cur", currentScore, 6);

    // False start during WAIT.
    pulse_start(8'd128);
    chk("fs_to_cleared", oTimeout, 0);
    wait_neg(20);
    pulse_resp();
    chk("fs_flag", oFalseStart, 1);
    chk("fs_done", oDone, 1);
    chk("fs_cur", currentScore, 6);
    chk("fs_trials", trialCount, 0);
    chk("fs_busy", oBusy, 0);

    // Response coinciding with a tick scores the pre-increment count.
    pulse_start(8'd0);
    chk("fs_cleared", oFalseStart, 0);
    wait_neg(30);
    chk("t4_stim", oStimulus, 1);
    wait_neg(19);
    pulse_resp();
    chk("t4_cur", currentScore, 1);
    chk("t4_high", highScore, 1);
    chk("t4_trials", trialCount, 1);

    // Session clear during GO does not abort the trial.
    pulse_start(8'd0);
    wait_neg(30);
    wait_neg(5);
    iClearSession = 1'b1;
    @(negedge clk);
    iClearSession = 1'b0;
    chk("t5_clr_high", highScore, 15);
    chk("t5_clr_trials", trialCount, 0);
    chk("t5_still_go", oStimulus, 1);
    wait_neg(24);
    pulse_resp();
    chk("t5_cur", currentScore, 3);
    chk("t5_high", highScore, 3);
    chk("t5_trials", trialCount, 1);

    // Clear and response on the same edge: clear wins for best/count.
    pulse_start(8'd0);
    wait_neg(30);
    wait_neg(10);
    iClearSession = 1'b1;
    iResponse     = 1'b1;
    @(negedge clk);
    iClearSession = 1'b0;
    iResponse     = 1'b0;
    chk("t6_cur", currentScore, 1);
    chk("t6_high", highScore, 15);
    chk("t6_trials", trialCount, 0);
    chk("t6_done", oDone, 1);

    // Reset during GO.
    pulse_start(8'd0);
    wait_neg(30);
    chk("t7_stim", oStimulus, 1);
    iReset = 1'b1;
    @(negedge clk);
    iReset = 1'b0;
    chk("t7_rst_stim", oStimulus, 0);
    chk("t7_rst_cur", currentScore, 0);
    chk("t7_rst_high", highScore, 15);
    chk("t7_rst_busy", oBusy, 0);
    chk("t7_rst_done", oDone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
Parametrised reaction-time measurement datapath and controller for the reaction benchmark.
- Divides the system clock into a measurement tick.
- Waits a PRNG-scaled random delay, then raises the stimulus and counts ticks until the player responds.
- Detects false starts and timeouts, and tracks the last, best and (optionally) average scores over a session of trials.
- Sits between the PRNG and the display/FSM top level.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 1000, measurement tick rate; DIV = CLK_HZ/TICK_HZ cycles per tick (DIV >= 2).
- SCORE_W, 12, score width in ticks; saturation value SMAX = 2^SCORE_W-1.
- PRNG_W, 8, width of the random input.
- DELAY_MIN, 3000, minimum random delay in ticks.
- DELAY_MAX, 6000, maximum random delay in ticks (DELAY_MAX > DELAY_MIN).
- TRIALS_LOG2, 2, trials per session = 2^TRIALS_LOG2.

Ports:
- clk  in  1  system clock.
- iReset  in  1  synchronous, active-high reset.
- iPRNG  in  PRNG_W  random value, sampled on accepted iStart.
- iStart  in  1  one-cycle pulse; begins a trial.
- iResponse  in  1  one-cycle pulse; player button.
- iClearSession  in  1  one-cycle pulse; clears best, average and trial count.
- oStimulus  out  1  high while in GO.
- oBusy  out  1  high in WAIT or GO.
- oDone  out  1  one-cycle pulse when a trial ends (valid, false start or timeout).
- oFalseStart  out  1  sticky flag; cleared on the next accepted iStart.
- oTimeout  out  1  sticky flag; cleared on the next accepted iStart.
- currentScore  out  SCORE_W  last valid reaction time in ticks.
- highScore  out  SCORE_W  lowest valid score this session; SMAX means none.
- trialCount  out  TRIALS_LOG2+1  valid trials completed this session (saturates at 2^TRIALS_LOG2).
- oSessionDone  out  1  high when trialCount == 2^TRIALS_LOG2.

Behaviour:
- Reset values: state IDLE; all flags and oDone 0; currentScore 0; highScore SMAX; trialCount 0; divider reloaded.
- Tick divider: down-counter from DIV-1. The tick is a single-cycle pulse when the count is 0. The divider reloads on an accepted iStart and on the WAIT->GO transition, so the first tick comes exactly DIV cycles after either event.
- Delay scaling, registered at accepted iStart:
  - delay = DELAY_MIN + ((iPRNG * (DELAY_MAX-DELAY_MIN)) >> PRNG_W).
  - No divider is used; intermediate width is PRNG_W + clog2(DELAY_MAX-DELAY_MIN+1).
  - Result is always in [DELAY_MIN, DELAY_MAX).
- FSM states: IDLE, WAIT, GO.
  - IDLE:
    - iStart accepted only if !oSessionDone. Then: latch the delay, clear oFalseStart and oTimeout, go to WAIT.
    - iResponse is ignored.
  - WAIT:
    - The delay counter decrements on each tick.
    - When it reaches 0 on a tick: go to GO, clear the score counter to 0.
    - iResponse in WAIT (including the same cycle as the final tick): set oFalseStart, pulse oDone, go to IDLE. No score update, trialCount unchanged.
  - GO:
    - oStimulus = 1; the score counter increments per tick.
    - iResponse: currentScore <= count; highScore <= min(highScore, count); trialCount++; pulse oDone; go to IDLE.
    - iResponse and a tick in the same cycle: the pre-increment count is used.
    - Count reaches SMAX: set oTimeout, pulse oDone, go to IDLE. No score or best update.
- iStart outside IDLE is ignored.
- iClearSession:
  - Accepted in any state. Sets highScore to SMAX and trialCount to 0 (and clears the average).
  - Does not abort a running trial.
  - If it coincides with a GO response, the clear takes priority for best/count; currentScore still updates.
- iReset mid-trial: immediate return to reset values; oStimulus falls the next cycle.
- All outputs are registered.

Optional Feature:
- Macro: REACTION_AVG_EN.
- When defined:
  - Adds output avgScore (SCORE_W).
  - Adds an accumulator of width SCORE_W+TRIALS_LOG2, which adds each valid score.
  - When trialCount reaches 2^TRIALS_LOG2: avgScore <= acc >> TRIALS_LOG2, one cycle after the final oDone.
  - Accumulator and avgScore reset to 0 on iReset and iClearSession.
- When undefined: no avgScore port and no accumulator logic.

Test Plan:
Common parameters: CLK_HZ=10, TICK_HZ=1 (DIV=10), DELAY_MIN=3, DELAY_MAX=7, SCORE_W=4, TRIALS_LOG2=1.
- Reset: apply iReset → highScore=15, currentScore=0, trialCount=0, oStimulus=0; all flags 0.
- Delay: iPRNG=128, iStart → oStimulus rises exactly 5 ticks (50 cycles) after iStart. With iPRNG=255: 6 ticks; with iPRNG=0: 3 ticks.
- Valid trial: iResponse 4 ticks after stimulus → currentScore=4, highScore=4, trialCount=1, oDone one cycle. A second trial with score 6 → highScore stays 4, trialCount=2, oSessionDone=1, and a further iStart is ignored. With REACTION_AVG_EN: avgScore=5.
- False start: iResponse during WAIT → oFalseStart=1, oDone pulse, scores and trialCount unchanged. The next iStart clears the flag.
- Timeout: no response → after 15 ticks in GO, oTimeout=1, oStimulus=0, highScore unchanged.
- Mid-trial controls: iReset during GO → all reset values next cycle. iClearSession during GO → highScore=15 and trialCount=0, and the trial still completes with currentScore updated.
